// File: rtl/mod_reg16_16to4_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES datapath types for the block serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef byte_t [15:0]      aes_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } ser_state_t;

endpackage : aes_pkg

`default_nettype wire

// File: rtl/mod_reg16_16to4_if.sv
// ============================================================================
// Module      : mod_reg16_16to4_in_if / mod_reg16_16to4_out_if
// Description : Block-side and beat-side valid/ready streams of the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mod_reg16_16to4_in_if #(
    parameter int NB = 16
);
    import aes_pkg::*;

    logic             i_valid;
    logic             i_ready;
    byte_t [NB-1:0]   i;

    modport master (output i_valid, output i, input  i_ready);
    modport slave  (input  i_valid, input  i, output i_ready);
endinterface : mod_reg16_16to4_in_if

interface mod_reg16_16to4_out_if #(
    parameter int NB = 4,
    parameter int CW = 2
);
    import aes_pkg::*;

    logic             o_valid;
    logic             o_ready;
    byte_t [NB-1:0]   o;
    logic [CW-1:0]    o_idx;
    logic             o_last;

    modport master (output o_valid, output o, output o_idx, output o_last, input o_ready);
    modport slave  (input  o_valid, input  o, input  o_idx, input  o_last, output o_ready);
endinterface : mod_reg16_16to4_out_if

`default_nettype wire

// File: rtl/mod_reg16_16to4.sv
// ============================================================================
// Module      : mod_reg16_16to4
// Description : Holds one parallel AES block and emits it as NIN/NOUT beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_reg16_16to4
    import aes_pkg::*;
#(
    parameter int NIN  = 16,
    parameter int NOUT = 4
) (
    input  wire                    clk,
    input  wire                    resetn,
    input  wire                    clr,
    mod_reg16_16to4_in_if.slave    s_in,
    mod_reg16_16to4_out_if.master  m_out
);

    localparam int BEATS = NIN / NOUT;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(BEATS - 1);

    ser_state_t                        r_state;
    byte_t [NIN-1:0]                   r_buf;
    logic  [CNT_W-1:0]                 r_idx;

    logic                              w_in_fire;
    logic                              w_out_fire;
    logic                              w_last;
    logic                              w_i_ready;
    logic  [BEATS-1:0][NOUT-1:0][BYTE_W-1:0] w_beats;

    // The buffer viewed as beats: beat k is bytes [NOUT*k +: NOUT].
    assign w_beats = r_buf;

    always_comb begin
        w_last     = (r_state == SEND) && (r_idx == C_LAST_IDX);
        w_out_fire = (r_state == SEND) && m_out.o_ready;
        // clr wins over everything, including a back-to-back reload.
        w_i_ready  = !clr && ((r_state == EMPTY) || (w_out_fire && w_last));
        w_in_fire  = s_in.i_valid && w_i_ready;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= EMPTY;
            r_buf   <= '0;
            r_idx   <= '0;
        end else if (clr) begin
            r_state <= EMPTY;
            r_idx   <= '0;
        end else if (w_in_fire) begin
            r_buf   <= s_in.i;
            r_idx   <= '0;
            r_state <= SEND;
        end else if (w_out_fire) begin
            if (w_last) begin
                r_idx   <= '0;
                r_state <= EMPTY;
            end else begin
                r_idx   <= r_idx + CNT_W'(1);
            end
        end
    end

    assign s_in.i_ready  = w_i_ready;
    assign m_out.o_valid = (r_state == SEND);
    assign m_out.o       = w_beats[r_idx];
    assign m_out.o_idx   = r_idx;
    assign m_out.o_last  = w_last;

endmodule : mod_reg16_16to4

`default_nettype wire

// File: tb/tb_mod_reg16_16to4.sv
// ============================================================================
// Module      : tb_mod_reg16_16to4
// Description : Directed and scoreboarded checks of the 16-to-4 byte serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_reg16_16to4;
    import aes_pkg::*;

    logic clk;
    logic resetn;
    logic clr;

    int n_vec;
    int n_err;

    mod_reg16_16to4_in_if  #(.NB(16))         bi ();
    mod_reg16_16to4_out_if #(.NB(4), .CW(2))  bo ();

    mod_reg16_16to4 #(.NIN(16), .NOUT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .s_in   (bi),
        .m_out  (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0][7:0] blk(input logic [7:0] base);
        logic [15:0][7:0] r;
        for (int b = 0; b < 16; b++) r[b] = base + 8'(b);
        return r;
    endfunction

    function automatic logic [31:0] beat(input logic [7:0] base, input int k);
        logic [7:0] b0;
        b0 = base + 8'(4 * k);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expects beats first..last of block `base` with o_ready=1, clr=0.
    task automatic drain(input logic [7:0] base, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            settle();
            chk("beat_valid", 32'(bo.o_valid), 32'd1);
            chk("beat_o",     bo.o,            beat(base, k));
            chk("beat_idx",   32'(bo.o_idx),   32'(k));
            chk("beat_last",  32'(bo.o_last),  32'(k == 3));
            chk("beat_irdy",  32'(bi.i_ready), 32'(k == 3));
            cyc();
        end
    endtask

    logic [15:0][7:0] cur;
    logic [31:0]      exp_q[$];
    int sent, lasts, bcnt, ncyc;

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        clr = 1'b0;
        bi.i_valid = 1'b0;
        bi.i = '0;
        bo.o_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 32'(bo.o_valid), 32'd0);
        chk("rst_o",     bo.o,            32'd0);
        chk("rst_idx",   32'(bo.o_idx),   32'd0);
        chk("rst_last",  32'(bo.o_last),  32'd0);
        chk("rst_irdy",  32'(bi.i_ready), 32'd1);
        cyc();
        resetn = 1'b1;
        cyc();

        // 1: single block, 1-cycle latency, 4 contiguous beats
        bi.i_valid = 1'b1; bi.i = blk(8'h00); bo.o_ready = 1'b1;
        settle();
        chk("t1_irdy",  32'(bi.i_ready), 32'd1);
        chk("t1_valid", 32'(bo.o_valid), 32'd0);
        cyc();
        bi.i_valid = 1'b0;
        drain(8'h00, 0, 3);
        settle();
        chk("t1_empty", 32'(bo.o_valid), 32'd0);
        cyc();

        // 2: stall on beat 1 for 3 cycles
        bi.i_valid = 1'b1; bi.i = blk(8'h00);
        cyc();
        bi.i_valid = 1'b0;
        drain(8'h00, 0, 0);
        bo.o_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            chk("t2_stall_o",   bo.o,            32'h07060504);
            chk("t2_stall_idx", 32'(bo.o_idx),   32'd1);
            chk("t2_stall_rdy", 32'(bi.i_ready), 32'd0);
            cyc();
        end
        bo.o_ready = 1'b1;
        drain(8'h00, 1, 3);
        settle();
        chk("t2_empty", 32'(bo.o_valid), 32'd0);
        cyc();

        // 3: back-to-back blocks, no bubble
        bi.i_valid = 1'b1; bi.i = blk(8'h00);
        settle();
        chk("t3_irdy", 32'(bi.i_ready), 32'd1);
        cyc();
        bi.i = blk(8'h10);
        drain(8'h00, 0, 3);
        bi.i_valid = 1'b0;
        drain(8'h10, 0, 3);
        settle();
        chk("t3_empty", 32'(bo.o_valid), 32'd0);
        cyc();

        // 4: asynchronous reset during beat 2
        bi.i_valid = 1'b1; bi.i = blk(8'h00);
        cyc();
        bi.i_valid = 1'b0;
        drain(8'h00, 0, 1);
        settle();
        chk("t4_pre_idx", 32'(bo.o_idx), 32'd2);
        #2 resetn = 1'b0;
        #1;
        chk("t4_rst_valid", 32'(bo.o_valid), 32'd0);
        chk("t4_rst_o",     bo.o,            32'd0);
        chk("t4_rst_idx",   32'(bo.o_idx),   32'd0);
        chk("t4_rst_irdy",  32'(bi.i_ready), 32'd1);
        #2 resetn = 1'b1;
        cyc();
        bi.i_valid = 1'b1; bi.i = blk(8'h20);
        settle();
        chk("t4_irdy", 32'(bi.i_ready), 32'd1);
        cyc();
        bi.i_valid = 1'b0;
        drain(8'h20, 0, 3);

        // 5: clr during beat 1 with a pending block
        bi.i_valid = 1'b1; bi.i = blk(8'h00);
        cyc();
        bi.i_valid = 1'b0;
        drain(8'h00, 0, 0);
        clr = 1'b1; bi.i_valid = 1'b1; bi.i = blk(8'h30);
        settle();
        chk("t5_clr_irdy",  32'(bi.i_ready), 32'd0);
        chk("t5_clr_valid", 32'(bo.o_valid), 32'd1);
        chk("t5_clr_idx",   32'(bo.o_idx),   32'd1);
        cyc();
        clr = 1'b0;
        settle();
        chk("t5_post_valid", 32'(bo.o_valid), 32'd0);
        chk("t5_post_idx",   32'(bo.o_idx),   32'd0);
        chk("t5_post_irdy",  32'(bi.i_ready), 32'd1);
        cyc();
        bi.i_valid = 1'b0;
        drain(8'h30, 0, 3);

        // 6: 100 random blocks, random backpressure, scoreboard
        sent = 0; lasts = 0; bcnt = 0; ncyc = 0;
        for (int b = 0; b < 16; b++) cur[b] = 8'($urandom);
        while ((sent < 100 || exp_q.size() > 0) && ncyc < 5000) begin
            bi.i_valid = (sent < 100);
            bi.i = cur;
            bo.o_ready = 1'($urandom_range(0, 1));
            settle();
            if (bo.o_valid && bo.o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_spurious", 32'd1, 32'd0);
                end else begin
                    chk("sb_o",    bo.o,           exp_q.pop_front());
                    chk("sb_last", 32'(bo.o_last), 32'(bcnt == 3));
                    if (bo.o_last) lasts++;
                    bcnt = (bcnt + 1) % 4;
                end
            end
            if (bi.i_valid && bi.i_ready) begin
                for (int k = 0; k < 4; k++) exp_q.push_back(cur[4*k +: 4]);
                sent++;
                for (int b = 0; b < 16; b++) cur[b] = 8'($urandom);
            end
            cyc();
            ncyc++;
        end
        bi.i_valid = 1'b0;
        chk("sb_timeout", 32'(ncyc < 5000), 32'd1);
        chk("sb_lasts",   32'(lasts),       32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mod_reg16_16to4

`default_nettype wire
